sample_player: RTL and testbench

SAMPLE_PLAYER -- requirements
Module: sample_player

---
 rtl/sample_player.sv | 198 +++++++++++++++++++
 tb/tb_sample_player.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_player.sv
// Table-driven I/Q sample player. A single table RAM is read through two
// registered ports (I at addr, Q at addr+q_offset). Samples are fetched at a
// programmable rate and presented on a valid/ready output with one cycle of
// read latency. Supports one-shot and continuous (looping) playback.
module sample_player #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] step,
  input  logic [ADDR_W-1:0] q_offset,
  input  logic [ADDR_W:0]   length,
  input  logic [DIV_W-1:0]  rate_div,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                inflight_q, inflight_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   oi_q, oi_d;
  logic [DATA_W-1:0]   oq_q, oq_d;
  logic                done_q, done_d;

  // Playback parameters captured at start so later input changes are ignored.
  logic                loop_q, loop_d;
  logic [ADDR_W-1:0]   step_q, step_d;
  logic [ADDR_W-1:0]   qoff_q, qoff_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [DIV_W-1:0]    rate_q, rate_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   q_addr;
  logic [DATA_W-1:0]   rd_i, rd_q;
  logic [ADDR_W:0]     addr_sum;
  logic                fetch;
  logic                start_ok;
  logic                last_fetch;
  logic                drain_exit;

  // Table writes are only accepted while idle so playback never sees a torn table.
  assign mem_we = wr_en && (state_q == ST_IDLE);

  // Table storage write port.
  // NOTE: the table RAM has no reset; its contents must survive rst and a
  // reset loop over every entry would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end

  assign q_addr   = addr_q + qoff_q;
  assign rd_i     = mem[addr_q];
  assign rd_q     = mem[q_addr];
  assign addr_sum = {1'b0, addr_q} + {1'b0, step_q};

  assign start_ok   = start && !stop && ((length != '0) || loop_en);
  assign fetch      = (state_q == ST_RUN) && (div_q == rate_q) && !stop &&
                      !inflight_q && (!valid_q || out_ready);
  assign last_fetch = (cnt_q + CNT_W'(1)) == len_q;
  assign drain_exit = (state_q == ST_DRAIN) && !inflight_q && (!valid_q || out_ready);

  // State and datapath registers; reset clears everything except the table.
  // NOTE: non-blocking assignments here so every flop samples the values from
  // before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      oi_q       <= '0;
      oq_q       <= '0;
      done_q     <= 1'b0;
      loop_q     <= 1'b0;
      step_q     <= '0;
      qoff_q     <= '0;
      len_q      <= '0;
      rate_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
      oi_q       <= oi_d;
      oq_q       <= oq_d;
      done_q     <= done_d;
      loop_q     <= loop_d;
      step_q     <= step_d;
      qoff_q     <= qoff_d;
      len_q      <= len_d;
      rate_q     <= rate_d;
    end
  end

  // Next-state logic for the playback FSM.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_RUN;
      ST_RUN:   if (stop || (fetch && !loop_q && last_fetch)) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_exit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: parameter capture, divider, address, output register.
  always_comb begin
    addr_d     = addr_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    loop_d     = loop_q;
    step_d     = step_q;
    qoff_d     = qoff_q;
    len_d      = len_q;
    rate_d     = rate_q;
    valid_d    = valid_q;
    oi_d       = oi_q;
    oq_d       = oq_q;
    inflight_d = fetch;
    done_d     = drain_exit ||
                 ((state_q == ST_IDLE) && start && !stop && (length == '0) && !loop_en);

    if ((state_q == ST_IDLE) && start_ok) begin
      loop_d = loop_en;
      step_d = step;
      qoff_d = q_offset;
      len_d  = length;
      rate_d = rate_div;
      addr_d = start_addr;
      div_d  = '0;
      cnt_d  = '0;
    end

    if (state_q == ST_RUN) begin
      if (fetch) begin
        addr_d = addr_sum[ADDR_W-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        div_d  = '0;
      end else if (div_q != rate_q) begin
        div_d = div_q + DIV_W'(1);
      end
    end

    // A fetch only happens when the output slot is empty or being drained,
    // so loading it never overwrites an untransferred sample.
    if (fetch) begin
      valid_d = 1'b1;
      oi_d    = rd_i;
      oq_d    = rd_q;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output mapping; wrap is flagged in the fetch cycle itself.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = done_q;
    out_valid = valid_q;
    out_i     = oi_q;
    out_q     = oq_q;
    wrap      = fetch && addr_sum[ADDR_W];
  end

endmodule

// File: tb/tb_sample_player.sv
// Self-checking bench for sample_player: directed scenarios with literal
// expectations plus randomized playbacks, all compared every cycle against a
// behavioural model and a per-transfer sample scoreboard.
module tb_sample_player;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 8;
  localparam int DIV_W  = 16;
  localparam int LEN_W  = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start, stop, loop_en;
  logic [ADDR_W-1:0] start_addr, step, q_offset;
  logic [LEN_W-1:0]  length;
  logic [DIV_W-1:0]  rate_div;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_i, out_q;
  logic              busy, done, wrap;

  sample_player #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .step(step), .q_offset(q_offset),
    .length(length), .rate_div(rate_div),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_i(out_i), .out_q(out_q),
    .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model state: playback phase plus abstract counters.
  int m_ph = PH_IDLE, m_addr = 0, m_div = 0, m_cnt = 0;
  int m_infl = 0, m_valid = 0, m_i = 0, m_q = 0, m_done = 0;
  int m_loop = 0, m_sa = 0, m_step = 0, m_qoff = 0, m_len = 0, m_rate = 0;
  int m_k = 0;
  int m_mem [DEPTH];
  bit m_fetch;

  // Logs of observed events for the directed literal checks.
  int tr_i[$], tr_q[$], tr_c[$], wrap_c[$], done_c[$];

  task automatic clear_logs();
    tr_i.delete(); tr_q.delete(); tr_c.delete(); wrap_c.delete(); done_c.delete();
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_addr = 0; m_div = 0; m_cnt = 0; m_infl = 0;
    m_valid = 0; m_i = 0; m_q = 0; m_done = 0; m_k = 0;
  endtask

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_step();
    bit xfer, drain_ok;
    xfer     = (m_valid != 0) && out_ready;
    drain_ok = (m_infl == 0) && ((m_valid == 0) || out_ready);
    m_done   = 0;
    case (m_ph)
      PH_IDLE: begin
        if (wr_en) m_mem[wr_addr] = int'(wr_data);
        if (start && !stop) begin
          if (length != 0 || loop_en) begin
            m_ph   = PH_RUN;
            m_loop = int'(loop_en);
            m_sa   = int'(start_addr);
            m_step = int'(step);
            m_qoff = int'(q_offset);
            m_len  = int'(length);
            m_rate = int'(rate_div);
            m_addr = m_sa; m_div = 0; m_cnt = 0; m_k = 0;
          end else begin
            m_done = 1;
          end
        end
      end
      PH_RUN: begin
        if (stop) m_ph = PH_DRAIN;
        else if (m_fetch) begin
          m_i     = m_mem[m_addr];
          m_q     = m_mem[(m_addr + m_qoff) % DEPTH];
          m_addr  = (m_addr + m_step) % DEPTH;
          m_cnt   = m_cnt + 1;
          m_div   = 0;
          if (m_loop == 0 && m_cnt == m_len) m_ph = PH_DRAIN;
        end else if (m_div < m_rate) m_div = m_div + 1;
      end
      PH_DRAIN: begin
        if (drain_ok) begin
          m_ph = PH_IDLE;
          m_done = 1;
        end
      end
      default: m_ph = PH_IDLE;
    endcase
    if (m_fetch) m_valid = 1;
    else if (xfer) m_valid = 0;
    m_infl = int'(m_fetch);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process: outputs are sampled mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (rst) model_reset();
    m_fetch = (m_ph == PH_RUN) && (m_div == m_rate) && !stop && (m_infl == 0) &&
              ((m_valid == 0) || out_ready);
    check("busy",      int'(busy),      int'(m_ph != PH_IDLE));
    check("done",      int'(done),      m_done);
    check("out_valid", int'(out_valid), m_valid);
    check("out_i",     int'(out_i),     m_i);
    check("out_q",     int'(out_q),     m_q);
    check("wrap",      int'(wrap),      int'(m_fetch && (m_addr + m_step >= DEPTH)));
    if (out_valid && out_ready) begin
      int a;
      a = (m_sa + m_k * m_step) % DEPTH;
      check("sb_i", int'(out_i), m_mem[a]);
      check("sb_q", int'(out_q), m_mem[(a + m_qoff) % DEPTH]);
      m_k = m_k + 1;
      tr_i.push_back(int'(out_i));
      tr_q.push_back(int'(out_q));
      tr_c.push_back(cyc);
    end
    if (wrap) wrap_c.push_back(cyc);
    if (done) done_c.push_back(cyc);
    if (!rst) model_step();
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic play(input bit lp, input int sa, input int st, input int qo,
                      input int ln, input int rd);
    loop_en    = lp;
    start_addr = ADDR_W'(sa);
    step       = ADDR_W'(st);
    q_offset   = ADDR_W'(qo);
    length     = LEN_W'(ln);
    rate_div   = DIV_W'(rd);
    start      = 1'b1;
    cyc_wait(1);
    start      = 1'b0;
    // Scramble the parameter inputs; the active playback must ignore them.
    loop_en    = 1'($urandom_range(0, 1));
    start_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
    step       = ADDR_W'($urandom_range(0, DEPTH - 1));
    q_offset   = ADDR_W'($urandom_range(0, DEPTH - 1));
    length     = LEN_W'($urandom_range(0, DEPTH));
    rate_div   = DIV_W'($urandom_range(0, 20));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      cyc_wait(1);
      n++;
    end
    check("idle_timeout", int'(busy), 0);
    cyc_wait(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hold_i;
    wr_en = 0; wr_addr = '0; wr_data = '0;
    start = 0; stop = 0; loop_en = 0;
    start_addr = '0; step = '0; q_offset = '0; length = '0; rate_div = '0;
    out_ready = 1;
    #1 rst = 1'b1;
    cyc_wait(3);
    rst = 1'b0;
    cyc_wait(1);

    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy",      int'(busy),      0);
    check("rst_done",      int'(done),      0);
    check("rst_out_i",     int'(out_i),     0);
    check("rst_wrap",      int'(wrap),      0);

    // Identity table: table[k] = k.
    for (int k = 0; k < DEPTH; k++) begin
      wr_en = 1; wr_addr = ADDR_W'(k); wr_data = DATA_W'(k);
      cyc_wait(1);
    end
    wr_en = 0;

    // One-shot, four samples at full rate.
    clear_logs();
    play(0, 0, 1, 64, 4, 0);
    wait_idle(100);
    check("os_count", tr_i.size(), 4);
    if (tr_i.size() >= 4) begin
      for (int j = 0; j < 4; j++) begin
        check("os_i", tr_i[j], j);
        check("os_q", tr_q[j], 64 + j);
      end
      check("os_spacing01", tr_c[1] - tr_c[0], 2);
      check("os_spacing23", tr_c[3] - tr_c[2], 2);
    end
    check("os_done_count", done_c.size(), 1);
    if (done_c.size() >= 1 && tr_c.size() >= 4)
      check("os_done_time", done_c[0], tr_c[3] + 2);

    // Looping playback across the top of the table.
    clear_logs();
    play(1, 254, 1, 64, 0, 0);
    cyc_wait(20);
    stop = 1; cyc_wait(1); stop = 0;
    wait_idle(50);
    check("loop_count_min", int'(tr_i.size() >= 6), 1);
    if (tr_i.size() >= 4) begin
      check("loop_i0", tr_i[0], 254);
      check("loop_i1", tr_i[1], 255);
      check("loop_i2", tr_i[2], 0);
      check("loop_i3", tr_i[3], 1);
      check("loop_q0", tr_q[0], 62);
    end
    check("loop_wrap_count", wrap_c.size(), 1);
    if (wrap_c.size() >= 1 && tr_c.size() >= 2)
      check("loop_wrap_time", wrap_c[0], tr_c[1] - 1);
    check("loop_done_count", done_c.size(), 1);

    // Slow rate: ten cycles between transfers.
    clear_logs();
    play(0, 10, 3, 5, 4, 9);
    wait_idle(200);
    check("slow_count", tr_i.size(), 4);
    if (tr_c.size() >= 4) begin
      check("slow_spacing01", tr_c[1] - tr_c[0], 10);
      check("slow_spacing23", tr_c[3] - tr_c[2], 10);
      check("slow_i1", tr_i[1], 13);
    end

    // Backpressure mid-run: output frozen, nothing lost or repeated.
    clear_logs();
    play(1, 100, 1, 0, 0, 0);
    cyc_wait(7);
    out_ready = 0;
    cyc_wait(1);
    hold_i = int'(out_i);
    check("bp_valid_start", int'(out_valid), 1);
    cyc_wait(19);
    check("bp_hold_i", int'(out_i), hold_i);
    check("bp_valid_end", int'(out_valid), 1);
    out_ready = 1;
    cyc_wait(10);
    stop = 1; cyc_wait(1); stop = 0;
    wait_idle(50);
    check("bp_count_min", int'(tr_i.size() >= 6), 1);
    for (int j = 0; j < tr_i.size(); j++) check("bp_seq", tr_i[j], (100 + j) % DEPTH);

    // Stop in a fetch-eligible cycle, with a table write attempted while busy.
    clear_logs();
    play(0, 0, 1, 0, 10, 9);
    n = 0;
    while (!(m_ph == PH_RUN && m_div == m_rate && m_infl == 0) && n < 50) begin
      cyc_wait(1);
      n++;
    end
    check("stopf_wait", int'(n < 50), 1);
    stop = 1; wr_en = 1; wr_addr = ADDR_W'(2); wr_data = DATA_W'(12'hABC);
    cyc_wait(1);
    stop = 0; wr_en = 0;
    wait_idle(20);
    check("stopf_no_fetch", tr_i.size(), 0);
    check("stopf_done", done_c.size(), 1);

    // Stop while a sample is held: it is still delivered before done.
    clear_logs();
    play(1, 50, 1, 0, 0, 0);
    cyc_wait(6);
    out_ready = 0;
    cyc_wait(3);
    stop = 1; cyc_wait(1); stop = 0;
    cyc_wait(5);
    check("drain_busy", int'(busy), 1);
    check("drain_valid", int'(out_valid), 1);
    out_ready = 1;
    wait_idle(20);
    for (int j = 0; j < tr_i.size(); j++) check("drain_seq", tr_i[j], 50 + j);
    check("drain_done", done_c.size(), 1);

    // Table must be unchanged by the write issued while busy.
    clear_logs();
    play(0, 0, 1, 0, 4, 0);
    wait_idle(50);
    if (tr_i.size() >= 3) check("busy_write_ignored", tr_i[2], 2);
    else check("busy_write_count", tr_i.size(), 4);

    // Asynchronous reset mid-run.
    clear_logs();
    play(1, 30, 1, 7, 0, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      cyc_wait(1);
      n++;
    end
    check("arst_wait", int'(out_valid), 1);
    rst = 1;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_out_i", int'(out_i), 0);
    check("arst_out_q", int'(out_q), 0);
    check("arst_busy",  int'(busy), 0);
    check("arst_done",  int'(done), 0);
    cyc_wait(1);
    rst = 0;
    cyc_wait(2);
    check("arst_no_done", done_c.size(), 0);
    clear_logs();
    play(0, 30, 1, 7, 3, 0);
    wait_idle(50);
    check("arst_replay_count", tr_i.size(), 3);
    if (tr_i.size() >= 1) begin
      check("arst_replay_i0", tr_i[0], 30);
      check("arst_replay_q0", tr_q[0], 37);
    end

    // Randomized table and playbacks.
    for (int k = 0; k < DEPTH; k++) begin
      wr_en = 1; wr_addr = ADDR_W'(k); wr_data = DATA_W'($urandom_range(0, 4095));
      cyc_wait(1);
    end
    wr_en = 0;
    for (int it = 0; it < 12; it++) begin
      bit lp;
      lp = 1'($urandom_range(0, 1));
      play(lp, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
           $urandom_range(0, DEPTH - 1), $urandom_range(0, 12), $urandom_range(0, 3));
      for (int c = 0; c < 80; c++) begin
        if (!busy) break;
        out_ready = ($urandom_range(0, 9) < 7);
        start     = ($urandom_range(0, 15) == 0);
        wr_en     = ($urandom_range(0, 7) == 0);
        wr_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
        wr_data   = DATA_W'($urandom_range(0, 4095));
        stop      = (lp && c == 60) || ($urandom_range(0, 63) == 0);
        cyc_wait(1);
      end
      start = 0; wr_en = 0; stop = 0; out_ready = 1;
      if (busy) begin
        stop = 1; cyc_wait(1); stop = 0;
      end
      wait_idle(200);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
